aidc_lite_decomp_zrle: RTL and testbench

//  ZRLE decompressor: the inverse of the ZRLE compressor. Consumes one compressed block as a

---
 rtl/aidc_lite_decomp_zrle.sv | 232 +++++++++++++++++++++++
 tb/tb_aidc_lite_decomp_zrle.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidc_lite_decomp_zrle.sv
// aidc_lite_decomp_zrle
//   Zero-run-length decompressor for one block of NUM_WORDS 64-bit words.
//   Compressed words enter MSB-first into a 128-bit left-aligned bit buffer.
//   At most one variable-length code is decoded per cycle, and each decoded
//   word is presented one cycle later.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_i / ready_o  compressed word handshake
//   sop_i / eop_i      first / last compressed word of a block
//   data_i             compressed word, bit 63 is the earliest stream bit
//   valid_o            decoded word valid (no backpressure)
//   addr_o, data_o     decoded word index and value
//   done_o             pulse with the last decoded word, or with err_o
//   err_o              pulse: block truncated or too many input words
//
// state  | meaning
// IDLE   | waiting for a word with sop_i; other words are dropped
// RUN    | filling the bit buffer and decoding one code per cycle
// FLUSH  | block fully decoded, discarding words until eop_i
module aidc_lite_decomp_zrle #(
  parameter int NUM_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        sop_i,
  input  logic        eop_i,
  input  logic [63:0] data_i,
  output logic        valid_o,
  output logic [2:0]  addr_o,
  output logic [63:0] data_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] MAX_IN   = CW'(NUM_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [127:0]    buf_q, buf_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [CW-1:0]   dec_cnt_q, dec_cnt_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic            eop_seen_q, eop_seen_d;
  logic            valid_o_q, valid_o_d;
  logic [2:0]      addr_o_q, addr_o_d;
  logic [63:0]     data_o_q, data_o_d;
  logic            done_o_q, done_o_d;
  logic            err_o_q, err_o_d;

  logic [5:0]      pfx;
  logic [15:0]     lane_a, lane_b, lane_c;
  logic [7:0]      hd_size;
  logic [63:0]     hd_word;
  logic            acc;
  logic            dec_ok;
  logic            dec_fire;
  logic            take;
  logic [127:0]    rem_buf;
  logic [7:0]      rem_cnt;

  assign pfx    = buf_q[127:122];
  assign lane_a = buf_q[123:108];
  assign lane_b = buf_q[107:92];
  assign lane_c = buf_q[91:76];

  // Head code size and decoded value. Bits below cnt_q are always zero, so
  // a partially filled prefix reads as if its missing bits were 0.
  always_comb begin
    hd_size = 8'd6;
    hd_word = '0;
    if (pfx[5:4] == 2'b11) begin
      hd_size = 8'd66;
      hd_word = buf_q[125:62];
    end else if (pfx[5]) begin
      hd_size = 8'd52;
      case (pfx[3:2])
        2'b00:   hd_word[47:0] = {lane_a, lane_b, lane_c};
        2'b01:   {hd_word[63:48], hd_word[31:0]} = {lane_a, lane_b, lane_c};
        2'b10:   {hd_word[63:32], hd_word[15:0]} = {lane_a, lane_b, lane_c};
        default: hd_word[63:16] = {lane_a, lane_b, lane_c};
      endcase
    end else if (pfx[4] | pfx[3]) begin
      hd_size = 8'd36;
      case (pfx[4:2])
        3'b010:  hd_word[31:0] = {lane_a, lane_b};
        3'b011:  {hd_word[47:32], hd_word[15:0]} = {lane_a, lane_b};
        3'b100:  {hd_word[63:48], hd_word[15:0]} = {lane_a, lane_b};
        3'b101:  hd_word[47:16] = {lane_a, lane_b};
        3'b110:  {hd_word[63:48], hd_word[31:16]} = {lane_a, lane_b};
        default: hd_word[63:32] = {lane_a, lane_b};
      endcase
    end else if (pfx[2] | pfx[1]) begin
      hd_size = 8'd21;
      case (pfx[2:1])
        2'b01:   hd_word[31:16] = buf_q[122:107];
        2'b10:   hd_word[47:32] = buf_q[122:107];
        default: hd_word[63:48] = buf_q[122:107];
      endcase
    end else if (pfx[0]) begin
      hd_size = 8'd22;
      hd_word[15:0] = buf_q[121:106];
    end
  end

  // Output process: the only combinational output
  always_comb begin
    ready_o = 1'b1;
    if (state_q == ST_RUN) ready_o = (cnt_q <= 8'd64);
  end

  assign acc    = valid_i & ready_o;
  assign dec_ok = (state_q == ST_RUN) && (hd_size <= cnt_q);

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    dec_cnt_d  = dec_cnt_q;
    in_cnt_d   = in_cnt_q;
    eop_seen_d = eop_seen_q;
    valid_o_d  = 1'b0;
    addr_o_d   = '0;
    data_o_d   = '0;
    done_o_d   = 1'b0;
    err_o_d    = 1'b0;
    dec_fire   = 1'b0;
    take       = 1'b0;
    rem_buf    = buf_q;
    rem_cnt    = cnt_q;

    if (acc && sop_i) begin
      // New block, also aborts any block in progress without a pulse
      state_d    = ST_RUN;
      buf_d      = {data_i, 64'b0};
      cnt_d      = 8'd64;
      dec_cnt_d  = '0;
      in_cnt_d   = CW'(1);
      eop_seen_d = eop_i;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (acc && eop_i) state_d = ST_IDLE;
        end
        ST_RUN: begin
          dec_fire = dec_ok;
          // Words arriving after eop belong to no block and are ignored
          take     = acc && !eop_seen_q;
          if (dec_fire) begin
            rem_buf   = buf_q << hd_size;
            rem_cnt   = cnt_q - hd_size;
            valid_o_d = 1'b1;
            addr_o_d  = dec_cnt_q[2:0];
            data_o_d  = hd_word;
            dec_cnt_d = dec_cnt_q + CW'(1);
          end
          if (dec_fire && dec_cnt_q == LAST_IDX) begin
            done_o_d = 1'b1;
            buf_d    = '0;
            cnt_d    = '0;
            state_d  = (eop_seen_q || (take && eop_i)) ? ST_IDLE : ST_FLUSH;
          end else if (take && in_cnt_q == MAX_IN) begin
            err_o_d  = 1'b1;
            done_o_d = 1'b1;
            buf_d    = '0;
            cnt_d    = '0;
            state_d  = eop_i ? ST_IDLE : ST_FLUSH;
          end else if (eop_seen_q && !dec_ok) begin
            // Whole block is in the buffer and the head code cannot complete
            err_o_d  = 1'b1;
            done_o_d = 1'b1;
            buf_d    = '0;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            buf_d = rem_buf;
            cnt_d = rem_cnt;
            if (take) begin
              buf_d      = rem_buf | ({data_i, 64'b0} >> rem_cnt);
              cnt_d      = rem_cnt + 8'd64;
              in_cnt_d   = in_cnt_q + CW'(1);
              eop_seen_d = eop_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      dec_cnt_q  <= '0;
      in_cnt_q   <= '0;
      eop_seen_q <= 1'b0;
      valid_o_q  <= 1'b0;
      addr_o_q   <= '0;
      data_o_q   <= '0;
      done_o_q   <= 1'b0;
      err_o_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      in_cnt_q   <= in_cnt_d;
      eop_seen_q <= eop_seen_d;
      valid_o_q  <= valid_o_d;
      addr_o_q   <= addr_o_d;
      data_o_q   <= data_o_d;
      done_o_q   <= done_o_d;
      err_o_q    <= err_o_d;
    end
  end

  assign valid_o = valid_o_q;
  assign addr_o  = addr_o_q;
  assign data_o  = data_o_q;
  assign done_o  = done_o_q;
  assign err_o   = err_o_q;

endmodule

// File: tb/tb_aidc_lite_decomp_zrle.sv
// Bench for aidc_lite_decomp_zrle: a bit-queue model decodes each block from
// the code table and queues the expected output events; a negedge process
// compares every DUT output event against that queue in order.
module tb_aidc_lite_decomp_zrle;

  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        sop_i = 1'b0;
  logic        eop_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        ready_o, valid_o, done_o, err_o;
  logic [2:0]  addr_o;
  logic [63:0] data_o;

  aidc_lite_decomp_zrle #(.NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .sop_i(sop_i), .eop_i(eop_i), .data_i(data_i), .valid_o(valid_o),
    .addr_o(addr_o), .data_o(data_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [63:0] data;
    logic        done;
    logic        err;
  } exp_t;

  localparam logic [3:0] M52 [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0] M36 [6] = '{4'b0011, 4'b0101, 4'b1001, 4'b0110, 4'b1010, 4'b1100};

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  exp_t        ev;
  logic [63:0] blk_w [8];
  int          blk_n;
  logic [63:0] model_word [NW];
  logic        model_err;
  bit          pk[$];
  time         acc_t, first_t, last_t;
  bit          ready_low_seen;
  logic [63:0] dd;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Stream-level model: walk the bitstream code by code using the table
  function automatic void model_decode();
    bit q[$];
    model_err = 1'b0;
    for (int i = 0; i < NW; i++) model_word[i] = '0;
    for (int i = 0; i < blk_n; i++)
      for (int b = 63; b >= 0; b--) q.push_back(blk_w[i][b]);
    for (int k = 0; k < NW; k++) begin
      int plen;
      int sz;
      logic [3:0]  mask;
      logic [5:0]  c6;
      logic [3:0]  c4;
      logic [63:0] w;
      exp_t        e;
      for (int i = 0; i < 6; i++) c6[5-i] = (i < q.size()) ? q[i] : 1'b0;
      c4 = c6[5:2];
      if (c6[5:4] == 2'b11) begin plen = 2; mask = 4'b1111; end
      else if (c4 >= 4'd8) begin plen = 4; mask = M52[int'(c4) - 8]; end
      else if (c4 >= 4'd2) begin plen = 4; mask = M36[int'(c4) - 2]; end
      else if (c6 == 6'd1) begin plen = 6; mask = 4'b0001; end
      else if (c6[5:1] != 5'd0) begin plen = 5; mask = 4'b0001 << c6[2:1]; end
      else begin plen = 6; mask = 4'b0000; end
      sz = plen + 16 * $countones(mask);
      if (sz > q.size()) begin
        e.addr = '0; e.data = '0; e.done = 1'b1; e.err = 1'b1;
        exp_q.push_back(e);
        model_err = 1'b1;
        return;
      end
      repeat (plen) void'(q.pop_front());
      w = '0;
      for (int l = 3; l >= 0; l--)
        if (mask[l]) for (int b = 15; b >= 0; b--) w[16*l+b] = q.pop_front();
      model_word[k] = w;
      e.addr = 3'(k); e.data = w; e.done = (k == NW - 1); e.err = 1'b0;
      exp_q.push_back(e);
    end
  endfunction

  task automatic put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pk.push_back(v[i]);
  endtask

  task automatic pack(input int nw);
    blk_n = nw;
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < 64; b++)
        blk_w[i][63-b] = (i * 64 + b < pk.size()) ? pk[i*64+b] : 1'b0;
    pk.delete();
  endtask

  task automatic send(input logic [63:0] d, input bit s, input bit e);
    int  g;
    bit  a;
    g = 0;
    a = 1'b0;
    valid_i = 1'b1; data_i = d; sop_i = s; eop_i = e;
    while (!a && g < 50) begin
      @(negedge clk);
      a = ready_o;
      if (a) acc_t = $time;
      @(posedge clk);
      #1;
      g++;
    end
    if (!a) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: actual ready_o 0 required 1");
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0;
  endtask

  task automatic send_blk();
    for (int i = 0; i < blk_n; i++) send(blk_w[i], i == 0, i == blk_n - 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!ready_o) ready_low_seen = 1'b1;
      if (valid_o || done_o || err_o) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_output: actual valid %0b addr %0d data %0h done %0b err %0b required none",
                   valid_o, addr_o, data_o, done_o, err_o);
        end else begin
          ev = exp_q.pop_front();
          check("out_event", {valid_o, addr_o, done_o, err_o, data_o},
                {~ev.err, ev.addr, ev.done, ev.err, ev.data});
          if (!ev.err && ev.addr == 3'd0) first_t = $time;
          if (!ev.err && ev.addr == 3'd7) last_t = $time;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {valid_o, done_o, err_o, addr_o, data_o}, '0);
    check("rst_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: all-zero single word block
    blk_w[0] = '0; blk_n = 1;
    model_decode();
    check("pin_t1_w7", model_word[7], 64'h0);
    ready_low_seen = 1'b0;
    send_blk();
    drain();
    check("t1_latency", 128'(first_t - acc_t), 128'd20);
    check("t1_burst", 128'(last_t - first_t), 128'd70);
    check("t1_ready_stayed", ready_low_seen, 1'b0);
    check("t1_idle_ready", ready_o, 1'b1);

    // 2: one L0 code then seven zero codes
    blk_w[0] = 64'h0448_D000_0000_0000; blk_n = 1;
    model_decode();
    check("pin_t2_w0", model_word[0], 64'h0000_0000_0000_1234);
    send_blk();
    drain();

    // 3: raw code spanning two words
    dd = 64'hDEAD_BEEF_0123_4567;
    blk_w[0] = {2'b11, dd[63:2]};
    blk_w[1] = {dd[1:0], 62'b0};
    blk_n = 2;
    model_decode();
    check("pin_t3_w0", model_word[0], 64'hDEAD_BEEF_0123_4567);
    ready_low_seen = 1'b0;
    send_blk();
    drain();
    check("t3_ready_drop", ready_low_seen, 1'b1);

    // 4: truncated raw code
    blk_w[0] = {2'b11, 62'h0}; blk_n = 1;
    model_decode();
    check("pin_t4_err", model_err, 1'b1);
    send_blk();
    drain();
    check("t4_idle_ready", ready_o, 1'b1);

    // 5a: three-word block mixing 21/36/52-bit codes
    put(5'b00011, 5); put(16'hA1A1, 16);
    put(4'b0100, 4);  put(16'hB2B2, 16); put(16'hC3C3, 16);
    put(4'b1000, 4);  put(16'h1111, 16); put(16'h2222, 16); put(16'h3333, 16);
    put(5'b00001, 5); put(16'h4444, 16);
    put(4'b0101, 4);  put(16'h5555, 16); put(16'h6666, 16);
    put(6'b0, 6); put(6'b0, 6); put(6'b0, 6);
    pack(3);
    model_decode();
    check("pin_t5_w0", model_word[0], 64'hA1A1_0000_0000_0000);
    check("pin_t5_w1", model_word[1], 64'hB2B2_0000_0000_C3C3);
    check("pin_t5_w2", model_word[2], 64'h0000_1111_2222_3333);
    check("pin_t5_w3", model_word[3], 64'h0000_0000_4444_0000);
    check("pin_t5_w4", model_word[4], 64'h0000_5555_6666_0000);
    send_blk();
    drain();

    // 5b: block stalled on an incomplete raw code, aborted by a new sop
    send({2'b11, 62'h0}, 1'b1, 1'b0);
    repeat (4) @(posedge clk); #1;
    model_decode();
    send_blk();
    drain();

    // 6: reset in the middle of a block, then a clean block
    blk_w[0] = '0; blk_n = 1;
    model_decode();
    send_blk();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_rst_outputs", {valid_o, done_o, err_o, addr_o, data_o}, '0);
    check("t6_rst_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    blk_w[0] = 64'h0448_D000_0000_0000; blk_n = 1;
    model_decode();
    send_blk();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
